college_marks_hub: RTL and testbench

- Synchronous register hub holding three 8-bit class marks: math, physics and lab.
- Access is split by role:
  - teacher port writes all three marks;
  - principal port reads all three and writes lab only;
  - student port is read-only, through a strobed snapshot.
- Sits between the role agents of the college subsystem as the single owner of the mark storage.

---
 rtl/college_marks_hub.sv | 93 +++++++++
 tb/tb_college_marks_hub.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/college_marks_hub.sv
// Mark register hub: teacher writes math/phys/lab, principal overrides lab, student reads a strobed snapshot.
// Latency: 1 cycle from write strobe or s_rd to registered outputs; all outputs registered.
// Backpressure: none, every strobe is consumed at the edge; COLLEGE_OVERRIDE_CNT_EN adds the override counter.
module college_marks_hub #(
    parameter int DATA_W   = 8,
    parameter int MAX_MARK = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t_wr_math,
    input  logic              t_wr_phys,
    input  logic              t_wr_lab,
    input  logic [DATA_W-1:0] t_math,
    input  logic [DATA_W-1:0] t_phys,
    input  logic [DATA_W-1:0] t_lab,
    input  logic              p_wr_lab,
    input  logic [DATA_W-1:0] p_lab,
    input  logic              s_rd,
    output logic [DATA_W-1:0] math,
    output logic [DATA_W-1:0] phys,
    output logic [DATA_W-1:0] lab,
    output logic              lab_src,
    output logic [DATA_W-1:0] s_math,
    output logic [DATA_W-1:0] s_phys,
    output logic [DATA_W-1:0] s_lab,
    output logic              s_valid,
    output logic              upd,
    output logic              err,
    output logic [7:0]        ovr_cnt
);

    localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_MARK);

    logic t_math_acc, t_phys_acc, t_lab_acc, p_lab_acc;
    logic any_rej, any_acc;

    always_comb begin
        t_math_acc = t_wr_math && (t_math <= MAX_V);
        t_phys_acc = t_wr_phys && (t_phys <= MAX_V);
        t_lab_acc  = t_wr_lab  && (t_lab  <= MAX_V);
        p_lab_acc  = p_wr_lab  && (p_lab  <= MAX_V);
        any_acc    = t_math_acc | t_phys_acc | t_lab_acc | p_lab_acc;
        any_rej    = (t_wr_math && !t_math_acc) | (t_wr_phys && !t_phys_acc) |
                     (t_wr_lab  && !t_lab_acc)  | (p_wr_lab  && !p_lab_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            math    <= '0;
            phys    <= '0;
            lab     <= '0;
            lab_src <= 1'b0;
            s_math  <= '0;
            s_phys  <= '0;
            s_lab   <= '0;
            s_valid <= 1'b0;
            upd     <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (t_math_acc) math <= t_math;
            if (t_phys_acc) phys <= t_phys;
            // Principal outranks teacher on a same-cycle lab write.
            if (p_lab_acc) begin
                lab     <= p_lab;
                lab_src <= 1'b1;
            end else if (t_lab_acc) begin
                lab     <= t_lab;
                lab_src <= 1'b0;
            end
            // Snapshot takes pre-edge values, so same-edge writes are excluded.
            if (s_rd) begin
                s_math <= math;
                s_phys <= phys;
                s_lab  <= lab;
            end
            s_valid <= s_rd;
            upd     <= any_acc;
            err     <= any_rej;
        end
    end

`ifdef COLLEGE_OVERRIDE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovr_cnt <= 8'd0;
        else if (p_lab_acc && ovr_cnt != 8'hff)
            ovr_cnt <= ovr_cnt + 8'd1;
    end
`else
    assign ovr_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_college_marks_hub.sv
// Directed self-checking bench for college_marks_hub.
module tb_college_marks_hub;

    logic       clk = 1'b0;
    logic       rst;
    logic       t_wr_math, t_wr_phys, t_wr_lab, p_wr_lab, s_rd;
    logic [7:0] t_math, t_phys, t_lab, p_lab;
    logic [7:0] math, phys, lab, s_math, s_phys, s_lab, ovr_cnt;
    logic       lab_src, s_valid, upd, err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ovr  = 0;

    college_marks_hub dut (
        .clk(clk), .rst(rst),
        .t_wr_math(t_wr_math), .t_wr_phys(t_wr_phys), .t_wr_lab(t_wr_lab),
        .t_math(t_math), .t_phys(t_phys), .t_lab(t_lab),
        .p_wr_lab(p_wr_lab), .p_lab(p_lab), .s_rd(s_rd),
        .math(math), .phys(phys), .lab(lab), .lab_src(lab_src),
        .s_math(s_math), .s_phys(s_phys), .s_lab(s_lab),
        .s_valid(s_valid), .upd(upd), .err(err), .ovr_cnt(ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then clear strobes; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        t_wr_math = 0; t_wr_phys = 0; t_wr_lab = 0; p_wr_lab = 0; s_rd = 0;
    endtask

    function automatic int ovr_exp(input int n);
`ifdef COLLEGE_OVERRIDE_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    initial begin
        rst = 1;
        t_wr_math = 0; t_wr_phys = 0; t_wr_lab = 0; p_wr_lab = 0; s_rd = 0;
        t_math = 0; t_phys = 0; t_lab = 0; p_lab = 0;
        step(); step();
        chk("rst_math", math, 0);
        chk("rst_phys", phys, 0);
        chk("rst_lab", lab, 0);
        chk("rst_lab_src", lab_src, 0);
        chk("rst_s_math", s_math, 0);
        chk("rst_s_phys", s_phys, 0);
        chk("rst_s_lab", s_lab, 0);
        chk("rst_s_valid", s_valid, 0);
        chk("rst_upd", upd, 0);
        chk("rst_err", err, 0);
        chk("rst_ovr", ovr_cnt, 0);
        rst = 0;

        // Teacher writes all three
        t_wr_math = 1; t_math = 85; t_wr_phys = 1; t_phys = 90; t_wr_lab = 1; t_lab = 95;
        step();
        chk("tw_math", math, 85);
        chk("tw_phys", phys, 90);
        chk("tw_lab", lab, 95);
        chk("tw_src", lab_src, 0);
        chk("tw_upd", upd, 1);
        chk("tw_err", err, 0);
        step();
        chk("tw_upd_drop", upd, 0);

        // Principal override
        p_wr_lab = 1; p_lab = 99;
        step();
        exp_ovr = 1;
        chk("po_lab", lab, 99);
        chk("po_src", lab_src, 1);
        chk("po_math", math, 85);
        chk("po_phys", phys, 90);
        chk("po_ovr", ovr_cnt, ovr_exp(exp_ovr));

        // Student snapshot
        s_rd = 1;
        step();
        chk("ss_math", s_math, 85);
        chk("ss_phys", s_phys, 90);
        chk("ss_lab", s_lab, 99);
        chk("ss_valid", s_valid, 1);
        chk("ss_upd", upd, 0);
        t_wr_lab = 1; t_lab = 70;
        step();
        chk("ss_valid_drop", s_valid, 0);
        chk("ss_live_lab", lab, 70);
        chk("ss_live_src", lab_src, 0);
        chk("ss_hold_lab", s_lab, 99);

        // Collision, both legal
        t_wr_lab = 1; t_lab = 80; p_wr_lab = 1; p_lab = 99;
        step();
        exp_ovr = 2;
        chk("col_lab", lab, 99);
        chk("col_src", lab_src, 1);
        chk("col_err", err, 0);
        chk("col_ovr", ovr_cnt, ovr_exp(exp_ovr));

        // Collision, principal illegal
        t_wr_lab = 1; t_lab = 80; p_wr_lab = 1; p_lab = 101;
        step();
        chk("col2_lab", lab, 80);
        chk("col2_src", lab_src, 0);
        chk("col2_err", err, 1);
        chk("col2_upd", upd, 1);
        chk("col2_ovr", ovr_cnt, ovr_exp(exp_ovr));

        // Out of range teacher write
        t_wr_math = 1; t_math = 150;
        step();
        chk("rng_math", math, 85);
        chk("rng_err", err, 1);
        chk("rng_upd", upd, 0);
        step();
        chk("rng_err_drop", err, 0);

        // Boundary: exactly MAX_MARK accepted, MAX_MARK+1 rejected
        t_wr_math = 1; t_math = 100;
        step();
        chk("bnd100_math", math, 100);
        chk("bnd100_err", err, 0);
        t_wr_math = 1; t_math = 101;
        step();
        chk("bnd101_math", math, 100);
        chk("bnd101_err", err, 1);

        // Snapshot coinciding with a write
        s_rd = 1; t_wr_phys = 1; t_phys = 60;
        step();
        chk("sw_s_phys", s_phys, 90);
        chk("sw_phys", phys, 60);
        chk("sw_s_math", s_math, 100);
        chk("sw_s_lab", s_lab, 80);
        chk("sw_valid", s_valid, 1);

        // Back-to-back requests keep s_valid high
        s_rd = 1;
        step();
        chk("bb_s_phys", s_phys, 60);
        chk("bb_valid1", s_valid, 1);
        s_rd = 1;
        step();
        chk("bb_valid2", s_valid, 1);
        step();
        chk("bb_valid_drop", s_valid, 0);

        // Identical rewrite still pulses upd
        t_wr_phys = 1; t_phys = 60;
        step();
        chk("same_upd", upd, 1);
        chk("same_phys", phys, 60);

        // Reset mid-operation discards strobes
        rst = 1; t_wr_math = 1; t_math = 50; p_wr_lab = 1; p_lab = 40; s_rd = 1;
        step();
        rst = 0;
        chk("mr_math", math, 0);
        chk("mr_lab", lab, 0);
        chk("mr_src", lab_src, 0);
        chk("mr_s_valid", s_valid, 0);
        chk("mr_s_math", s_math, 0);
        chk("mr_upd", upd, 0);
        chk("mr_ovr", ovr_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
